// File: rtl/quantum_timer.sv
// ============================================================================
// Module   : quantum_timer
// Brief    : Preemption quantum timer; counts retired user instructions and
//            pulses timerInt when the programmed quantum is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quantum_timer #(
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned DEFAULT_QUANTUM = 100,
  parameter int unsigned PREEMPT_WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     enable,
  input  logic                     instrRetire,
  input  logic                     changeContext,
  input  logic                     quantumWrite,
  input  logic [COUNT_WIDTH-1:0]   quantumData,
  output logic                     timerInt,
  output logic [COUNT_WIDTH-1:0]   remaining,
  output logic [PREEMPT_WIDTH-1:0] preemptCount,
  output logic [1:0]               state
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUNNING = 2'd1;
  localparam logic [1:0] c_EXPIRED = 2'd2;
  localparam logic [1:0] c_WAIT    = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] c_DEFAULT_Q = COUNT_WIDTH'(DEFAULT_QUANTUM);
  localparam logic [COUNT_WIDTH-1:0] c_ONE       = COUNT_WIDTH'(1);

  logic [1:0]               r_state;
  logic [COUNT_WIDTH-1:0]   r_quantum;
  logic [COUNT_WIDTH-1:0]   r_remaining;
  logic                     r_timer_int;
  logic [PREEMPT_WIDTH-1:0] r_preempt_count;

  logic [1:0]               w_next_state;
  logic [COUNT_WIDTH-1:0]   w_next_remaining;
  logic [COUNT_WIDTH-1:0]   w_reload_val;
  logic                     w_tick;

  // A write in the same cycle as a reload is forwarded into the reload.
  assign w_reload_val = quantumWrite ? quantumData : r_quantum;
  assign w_tick       = enable && instrRetire && (r_quantum != '0);

  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    case (r_state)
      c_IDLE: begin
        if (changeContext) w_next_remaining = w_reload_val;
        if (enable)        w_next_state     = c_RUNNING;
      end
      c_RUNNING: begin
        if (changeContext) begin
          w_next_remaining = w_reload_val;
        end else if (w_tick && (r_remaining == c_ONE)) begin
          w_next_remaining = '0;
          w_next_state     = c_EXPIRED;
        end else if (w_tick && (r_remaining != '0)) begin
          w_next_remaining = r_remaining - c_ONE;
        end
      end
      c_EXPIRED: begin
        if (changeContext) begin
          w_next_remaining = w_reload_val;
          w_next_state     = c_RUNNING;
        end else begin
          w_next_state     = c_WAIT;
        end
      end
      default: begin
        if (changeContext) begin
          w_next_remaining = w_reload_val;
          w_next_state     = enable ? c_RUNNING : c_IDLE;
        end
      end
    endcase
  end

  // The pulse and the event count are registered off the EXPIRED state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state         <= c_IDLE;
      r_quantum       <= c_DEFAULT_Q;
      r_remaining     <= c_DEFAULT_Q;
      r_timer_int     <= 1'b0;
      r_preempt_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
      r_timer_int <= (r_state == c_EXPIRED);
      if (quantumWrite)          r_quantum       <= quantumData;
      if (r_state == c_EXPIRED)  r_preempt_count <= r_preempt_count + 1'b1;
    end
  end

  assign state        = r_state;
  assign remaining    = r_remaining;
  assign timerInt     = r_timer_int;
  assign preemptCount = r_preempt_count;

endmodule

`default_nettype wire

// File: tb/tb_quantum_timer.sv
// ============================================================================
// Module   : tb_quantum_timer
// Brief    : Directed and randomized checks of quantum_timer against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quantum_timer;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        instrRetire = 1'b0;
  logic        changeContext = 1'b0;
  logic        quantumWrite = 1'b0;
  logic [15:0] quantumData = '0;
  logic        timerInt;
  logic [15:0] remaining;
  logic [7:0]  preemptCount;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase names, counts held as plain integers.
  typedef enum int {P_IDLE = 0, P_RUN = 1, P_EXP = 2, P_WAIT = 3} phase_t;
  phase_t m_phase;
  int     m_quantum;
  int     m_left;
  int     m_pulse;
  int     m_fired;

  quantum_timer #(
    .COUNT_WIDTH(16), .DEFAULT_QUANTUM(100), .PREEMPT_WIDTH(8)
  ) dut (
    .clock(clock), .resetN(resetN), .enable(enable), .instrRetire(instrRetire),
    .changeContext(changeContext), .quantumWrite(quantumWrite),
    .quantumData(quantumData), .timerInt(timerInt), .remaining(remaining),
    .preemptCount(preemptCount), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_quantum = 100; m_left = 100; m_pulse = 0; m_fired = 0;
  endtask

  task automatic model_edge(input bit en, input bit ret, input bit cc,
                            input bit qw, input int qd);
    int reload;
    bit counts;
    reload = qw ? qd : m_quantum;
    counts = en && ret && (m_quantum > 0);
    m_pulse = (m_phase == P_EXP);
    if (m_pulse) m_fired = (m_fired + 1) % 256;
    if (cc) begin
      m_left = reload;
      if (m_phase == P_EXP) m_phase = P_RUN;
      else if (m_phase != P_RUN) m_phase = en ? P_RUN : P_IDLE;
    end else if (m_phase == P_IDLE) begin
      if (en) m_phase = P_RUN;
    end else if (m_phase == P_EXP) begin
      m_phase = P_WAIT;
    end else if (m_phase == P_RUN && counts && m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = P_EXP;
    end
    if (qw) m_quantum = qd;
  endtask

  task automatic check_all(input string where);
    chk({where, ".timerInt"},     int'(timerInt),     m_pulse);
    chk({where, ".remaining"},    int'(remaining),    m_left);
    chk({where, ".preemptCount"}, int'(preemptCount), m_fired);
    chk({where, ".state"},        int'(state),        int'(m_phase));
  endtask

  task automatic step(input bit en, input bit ret, input bit cc,
                      input bit qw, input int qd);
    enable = en; instrRetire = ret; changeContext = cc;
    quantumWrite = qw; quantumData = 16'(qd);
    @(posedge clock);
    model_edge(en, ret, cc, qw, qd);
    #1;
    check_all("cycle");
  endtask

  // Retire continuously until the pulse appears; returns steps taken (0 = none).
  task automatic run_to_pulse(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step(1, 1, 0, 0, 0);
      if (timerInt) begin n = i; break; end
    end
  endtask

  task automatic async_reset(input string tag);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clock);
    #1 resetN = 1'b1;
    check_all({tag, ".held"});
  endtask

  initial begin
    int n;
    int pulses;
    bit tog;
    model_reset();
    #12;
    check_all("reset");
    resetN = 1'b1;

    // Full default quantum: 1 edge to RUNNING, 99 decrements, expiry, pulse.
    run_to_pulse(200, n);
    chk("first_expiry_steps", n, 102);
    chk("first_expiry_count", int'(preemptCount), 1);
    chk("first_expiry_state", int'(state), 3);

    step(1, 0, 1, 0, 0);
    chk("wait_reload", int'(remaining), 100);
    run_to_pulse(200, n);
    chk("second_expiry_steps", n, 101);

    // Quantum write mid-count only affects the next reload.
    step(1, 0, 1, 0, 0);
    repeat (60) step(1, 1, 0, 0, 0);
    chk("mid_count", int'(remaining), 40);
    step(1, 0, 0, 1, 5);
    chk("write_no_effect", int'(remaining), 40);
    run_to_pulse(100, n);
    chk("old_quantum_steps", n, 41);
    step(1, 0, 1, 0, 0);
    run_to_pulse(100, n);
    chk("new_quantum_steps", n, 6);

    // Context switch on the final retire wins over expiry.
    step(1, 0, 1, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    chk("at_one", int'(remaining), 1);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("cc_beats_expiry_int", int'(timerInt), 0);
    chk("cc_beats_expiry_rem", int'(remaining), 5);

    // Alternating retires, then a kernel excursion freezes the count.
    step(1, 0, 1, 1, 100);
    tog = 1'b0;
    for (int i = 0; i < 400 && m_left != 7; i++) begin
      tog = ~tog;
      step(1, tog, 0, 0, 0);
    end
    repeat (10) step(0, 1, 0, 0, 0);
    chk("frozen", int'(remaining), 7);
    run_to_pulse(20, n);
    chk("resume_steps", n, 8);

    // Zero quantum disables the timer entirely.
    step(0, 0, 1, 1, 0);
    chk("zero_reload", int'(remaining), 0);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 1, 0, 0, 0);
      if (timerInt) pulses++;
    end
    chk("zero_no_pulse", pulses, 0);

    // Asynchronous reset while EXPIRED, then while the pulse is high.
    step(1, 0, 1, 1, 3);
    for (int i = 0; i < 20 && m_phase != P_EXP; i++) step(1, 1, 0, 0, 0);
    chk("reached_expired", int'(state), 2);
    async_reset("rst_in_expired");
    step(1, 0, 0, 1, 2);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 20 && !timerInt; i++) step(1, 1, 0, 0, 0);
    chk("pulse_before_rst", int'(timerInt), 1);
    async_reset("rst_in_pulse");

    // Randomized traffic with small quanta so expiries are frequent.
    for (int i = 0; i < 3000; i++) begin
      bit en, ret, cc, qw;
      en  = ($urandom_range(0, 9) != 0);
      ret = ($urandom_range(0, 3) != 0);
      cc  = ($urandom_range(0, 15) == 0);
      qw  = ($urandom_range(0, 31) == 0);
      step(en, ret, cc, qw, int'($urandom_range(0, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quantum_timer.md
Name: quantum_timer

Overview:
- Preemption quantum timer directly upstream of the interruption controller; generates its `timerInt` input.
- Counts retired instructions of the running user process and raises a one-cycle `timerInt` pulse when the programmed quantum is exhausted.
- Reloads on every context change, so each process gets a full quantum.
- Quantum is software-programmable through a write port driven by the kernel's store path.

Parameters:
- COUNT_WIDTH, 16, width of quantum register and down-counter.
- DEFAULT_QUANTUM, 100, quantum loaded at reset; must be nonzero and fit COUNT_WIDTH.
- PREEMPT_WIDTH, 8, width of the preemption event counter.

Ports:
- clock  in  1  system clock, rising-edge.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  1 = user process running (driven from controller `region`); 0 = kernel/idle.
- instrRetire  in  1  one instruction retired this cycle (0 during halt/stall).
- changeContext  in  1  context switch this cycle; same signal the controller consumes.
- quantumWrite  in  1  write strobe for the quantum register.
- quantumData  in  COUNT_WIDTH  new quantum value.
- timerInt  out  1  preemption request, one-cycle pulse, registered.
- remaining  out  COUNT_WIDTH  current down-counter value.
- preemptCount  out  PREEMPT_WIDTH  number of timerInt pulses issued, wraps.
- state  out  2  FSM state: IDLE=0, RUNNING=1, EXPIRED=2, WAIT=3.

Behaviour:
Reset (async, resetN=0):
- state=IDLE, quantumReg=DEFAULT_QUANTUM, remaining=DEFAULT_QUANTUM, timerInt=0, preemptCount=0.
- All outputs are registered.

Quantum register:
- On quantumWrite, quantumReg<=quantumData.
- A new value takes effect only at the next reload; a running count is not altered.
- If quantumWrite and a reload occur in the same cycle, the reload uses quantumData (write forwarded).

Reload:
- Sets remaining<=effective quantum.

Decrement condition:
- tick = enable && instrRetire && quantumReg!=0.

FSM:
- IDLE: remaining held. enable=1 -> RUNNING. changeContext -> reload, stay IDLE.
- RUNNING:
  - changeContext -> reload, stay RUNNING; no pulse. Takes priority over expiry in the same cycle.
  - Else if tick and remaining==1 -> remaining<=0, go EXPIRED.
  - Else if tick -> remaining<=remaining-1.
  - enable=0 -> counter frozen, state stays RUNNING. The quantum is preserved across kernel excursions without a switch.
- EXPIRED:
  - timerInt=1 for exactly this one cycle; preemptCount increments (wraps at 2^PREEMPT_WIDTH-1 -> 0).
  - Next cycle -> WAIT unconditionally.
  - A changeContext arriving in EXPIRED reloads remaining and goes to RUNNING; the pulse is still issued.
- WAIT: kernel handler running; timerInt=0, remaining held at 0. changeContext -> reload; next state RUNNING if enable else IDLE.

Latency:
- The retire that drives remaining 1->0 at edge k makes timerInt high from edge k+1 to k+2.
- The controller samples it at edge k+2.

Boundary conditions:
- quantumReg=0: timer disabled; no ticks, never expires; remaining reloads to 0.
- Expiry with enable=0 is impossible: no tick occurs.
- instrRetire without enable is ignored.
- Counter never underflows below 0.
- Reset mid-count or in EXPIRED: pulse aborted immediately (async), preemptCount cleared.
- Back-to-back switches each reload; no pulse results.

Test Plan:
- Reset, enable=1, instrRetire=1 continuously, DEFAULT_QUANTUM=100 -> remaining 100->1 over 99 edges; 100th retire -> timerInt high exactly 1 cycle; preemptCount=1; state=WAIT.
- In WAIT, pulse changeContext with enable=1 -> remaining=100, state=RUNNING; no further timerInt until 100 more retires.
- quantumWrite 5 mid-count (remaining=40) -> count continues 40->0; after the next changeContext, expiry after exactly 5 retires.
- remaining=1, changeContext and instrRetire same cycle -> no timerInt, remaining=quantum, state RUNNING.
- Toggle instrRetire 0/1 alternately, then enable=0 for 10 cycles at remaining=7 -> remaining holds 7; counting resumes on re-enable; expiry occurs only after 7 more retires.
- quantumWrite 0, then changeContext -> remaining=0, no timerInt over 1000 retires. Separately, assert resetN=0 during EXPIRED -> timerInt and preemptCount go 0 immediately.
